conv_mac_pipe: RTL
==================

Name: conv_mac_pipe

Overview:
Parametrised, pipelined signed multiply-accumulate engine for the convolution kernels; the successor to the single-cycle 16x8 combinational multiplier.
- Multiplies a stream of signed operand pairs and sums ACC_LEN consecutive products, e.g. 9 for a 3x3 tap window.
- Emits one scaled result per window through a valid/ready output stage.
- Sits between the line-buffer/weight fetch and the output writer of each conv layer.

Parameters:
- DIN0_WIDTH, 16, signed activation width.
- DIN1_WIDTH, 8, signed weight width.
- ACC_WIDTH, 32, signed accumulator width; must be >= DIN0_WIDTH+DIN1_WIDTH+clog2(ACC_LEN).
- DOUT_WIDTH, 24, signed result width.
- NUM_STAGE, 2, multiplier pipeline registers; must be >= 1.
- ACC_LEN, 9, products per window; must be >= 1.
- OUT_SHIFT, 0, arithmetic right shift applied to the final sum.

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  asynchronous active-low reset.
- ce  in  1  global clock enable; when low, all state holds.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  operand pair accepted when in_valid && in_ready.
- din0  in  DIN0_WIDTH  signed activation.
- din1  in  DIN1_WIDTH  signed weight.
- acc_clr  in  1  abort the current window.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- dout  out  DOUT_WIDTH  signed window result.
- busy  out  1  a partial window or in-flight product exists.

Behaviour:
- Reset (async assert, sync release): out_valid=0, dout=0, busy=0. Pipeline valid bits, tap counter and accumulator all clear.
- in_ready is combinational: ce && !acc_clr && (!out_valid || out_ready).
- adv = ce && (!out_valid || out_ready). All pipeline and accumulator registers update only when adv=1.
- Global stall: out_valid && !out_ready freezes the whole pipe, and dout holds stable.
- Multiplier: full-precision signed product of width DIN0_WIDTH+DIN1_WIDTH, carried through NUM_STAGE registers with a valid bit per stage.
- Accumulator: tap counter 0..ACC_LEN-1. When a valid product leaves the last stage:
  - tap 0: acc = sext(product).
  - other taps: acc = acc + sext(product), wrapping two's-complement in ACC_WIDTH.
  - Counter increments, and wraps to 0 after ACC_LEN-1.
- Final tap (ACC_LEN-1): on the same adv edge, dout <= fmt(acc + product) and out_valid <= 1.
- ACC_LEN=1: every product is a result.
- fmt(x) = (x >>> OUT_SHIFT), truncated to DOUT_WIDTH (wrap), or saturated when the optional feature is enabled.
- Latency: last operand of a window accepted at adv edge k gives out_valid=1 after edge k+NUM_STAGE+1. Windows pipeline back-to-back at one operand per cycle with no bubbles.
- out_valid drops after an edge with out_ready=1 unless a new result loads on that edge.
- acc_clr=1 with ce=1 at an edge:
  - Pipeline valid bits, tap counter and accumulator clear.
  - A pending out_valid/dout is kept.
  - in_ready is low, so simultaneous input is dropped.
  - acc_clr with ce=0 is ignored.
- busy = any stage valid || counter != 0.
- Reset mid-window discards everything; there is no partial result.

Optional Feature:
- Macro CONV_MAC_SAT_EN.
- Defined: fmt saturates the shifted sum to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1], and an extra output port sat_flag (1 bit) is registered alongside dout, high when clipping occurred; sat_flag resets to 0.
- Undefined: plain truncation to the low DOUT_WIDTH bits, and the sat_flag port does not exist.

Decomposition:
- Package conv_mac_pkg holds:
  - clog2 constant function.
  - Derived constants PROD_WIDTH and TAP_CNT_WIDTH.
  - Elaboration checks for the ACC_WIDTH, NUM_STAGE and ACC_LEN constraints.
- Sub-module conv_mac_mul_pipe: signed multiplier with NUM_STAGE registers, a valid shift chain, and enable/flush inputs; it is the DSP-inferable core.
- The accumulator, counter, output stage and formatter live in conv_mac_pipe.

Test Plan:
- Defaults, 9 pairs (100, 3) at full rate with out_ready=1 -> dout=2700, out_valid exactly one cycle, at NUM_STAGE+1=3 cycles after the last accept.
- 9 pairs (-32768, -128) -> with CONV_MAC_SAT_EN: dout=8388607, sat_flag=1. Without it: dout=4194304.
- 18 back-to-back pairs, window 1 (1, 1), window 2 (-2, 5) -> results 9 then -90, nine cycles apart, no bubbles.
- Hold out_ready=0 with a result pending while feeding input -> in_ready=0, dout held. Release -> the next result arrives with the correct value and no lost operands.
- 4 pairs (7, 7), then acc_clr for 1 cycle, then 9 pairs (1, 1) -> single result 9, busy=0 afterwards.
- ap_rst_n low for 2 cycles mid-window after 5 taps, then 9 pairs (2, 2) -> out_valid=0 during reset, then a single result 36.

Source files
------------

// File: rtl/conv_mac_pkg.sv
// Shared helpers for the conv MAC engine: width derivation and configuration checks.
// Used by conv_mac_pipe and conv_mac_mul_pipe.
package conv_mac_pkg;

  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // PROD_WIDTH: full-precision signed product width.
  function automatic int prod_width(input int din0_w, input int din1_w);
    return din0_w + din1_w;
  endfunction

  // TAP_CNT_WIDTH: tap counter width, at least one bit even for single-tap windows.
  function automatic int tap_cnt_width(input int acc_len);
    return (acc_len > 1) ? clog2(acc_len) : 1;
  endfunction

  function automatic bit acc_width_ok(input int acc_w, input int din0_w, input int din1_w,
                                      input int acc_len);
    return acc_w >= prod_width(din0_w, din1_w) + clog2(acc_len);
  endfunction

endpackage

// File: rtl/conv_mac_mul_pipe.sv
// Signed multiplier core: registered operands, then NUM_STAGE product registers with a
// valid shift chain. Data registers carry no reset so the core maps onto a DSP slice.
module conv_mac_mul_pipe #(
  parameter int A_WIDTH    = 16,
  parameter int B_WIDTH    = 8,
  parameter int NUM_STAGE  = 2,
  parameter int PROD_WIDTH = A_WIDTH + B_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_en,
  input  logic                         i_flush,
  input  logic                         i_valid,
  input  logic signed [A_WIDTH-1:0]    i_a,
  input  logic signed [B_WIDTH-1:0]    i_b,
  output logic signed [PROD_WIDTH-1:0] o_prod,
  output logic                         o_valid,
  output logic                         o_busy
);

  logic signed [A_WIDTH-1:0]    r_a;
  logic signed [B_WIDTH-1:0]    r_b;
  logic                         r_op_vld;
  logic signed [PROD_WIDTH-1:0] r_prod [NUM_STAGE];
  logic [NUM_STAGE-1:0]         r_vld;
  logic signed [PROD_WIDTH-1:0] w_mul;

  assign w_mul = PROD_WIDTH'(r_a) * PROD_WIDTH'(r_b);

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_a       <= i_a;
      r_b       <= i_b;
      r_prod[0] <= w_mul;
      for (int s = 1; s < NUM_STAGE; s++) begin
        r_prod[s] <= r_prod[s-1];
      end
    end
  end

  // Flush wins over enable so an aborted window cannot leak a product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_vld <= 1'b0;
      r_vld    <= '0;
    end else if (i_flush) begin
      r_op_vld <= 1'b0;
      r_vld    <= '0;
    end else if (i_en) begin
      r_op_vld <= i_valid;
      r_vld[0] <= r_op_vld;
      for (int s = 1; s < NUM_STAGE; s++) begin
        r_vld[s] <= r_vld[s-1];
      end
    end
  end

  assign o_prod  = r_prod[NUM_STAGE-1];
  assign o_valid = r_vld[NUM_STAGE-1];
  assign o_busy  = r_op_vld || (|r_vld);

endmodule

// File: rtl/conv_mac_pipe.sv
// Pipelined signed MAC: sums ACC_LEN products per window and emits one scaled result.
// CONV_MAC_SAT_EN selects saturating output formatting and adds the sat_flag port.
module conv_mac_pipe
  import conv_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int DOUT_WIDTH = 24,
  parameter int NUM_STAGE  = 2,
  parameter int ACC_LEN    = 9,
  parameter int OUT_SHIFT  = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  acc_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  busy
`ifdef CONV_MAC_SAT_EN
  ,
  output logic                  sat_flag
`endif
);

  localparam int PROD_WIDTH    = prod_width(DIN0_WIDTH, DIN1_WIDTH);
  localparam int TAP_CNT_WIDTH = tap_cnt_width(ACC_LEN);
  localparam logic [TAP_CNT_WIDTH-1:0] TAP_LAST = TAP_CNT_WIDTH'(ACC_LEN - 1);

  if (!acc_width_ok(ACC_WIDTH, DIN0_WIDTH, DIN1_WIDTH, ACC_LEN)) begin : g_bad_acc_width
    $error("conv_mac_pipe: ACC_WIDTH too narrow for DIN0_WIDTH+DIN1_WIDTH+clog2(ACC_LEN)");
  end
  if (NUM_STAGE < 1) begin : g_bad_num_stage
    $error("conv_mac_pipe: NUM_STAGE must be >= 1");
  end
  if (ACC_LEN < 1) begin : g_bad_acc_len
    $error("conv_mac_pipe: ACC_LEN must be >= 1");
  end
  if (DOUT_WIDTH > ACC_WIDTH) begin : g_bad_dout_width
    $error("conv_mac_pipe: DOUT_WIDTH must not exceed ACC_WIDTH");
  end

  logic                         r_out_valid;
  logic [DOUT_WIDTH-1:0]        r_dout;
  logic [TAP_CNT_WIDTH-1:0]     r_tap;
  logic signed [ACC_WIDTH-1:0]  r_acc;

  logic                         w_adv;
  logic                         w_clr;
  logic                         w_accept;
  logic                         w_fire;
  logic                         w_load;
  logic signed [PROD_WIDTH-1:0] w_prod;
  logic                         w_prod_vld;
  logic                         w_pipe_busy;
  logic signed [ACC_WIDTH-1:0]  w_prod_ext;
  logic signed [ACC_WIDTH-1:0]  w_base;
  logic signed [ACC_WIDTH-1:0]  w_sum;
  logic signed [ACC_WIDTH-1:0]  w_shifted;
  logic [DOUT_WIDTH-1:0]        w_fmt;

  // A pending result that downstream refuses freezes everything upstream of it.
  assign w_adv    = ce && (!r_out_valid || out_ready);
  assign w_clr    = ce && acc_clr;
  assign in_ready = w_adv && !acc_clr;
  assign w_accept = in_valid && in_ready;

  conv_mac_mul_pipe #(
    .A_WIDTH    (DIN0_WIDTH),
    .B_WIDTH    (DIN1_WIDTH),
    .NUM_STAGE  (NUM_STAGE),
    .PROD_WIDTH (PROD_WIDTH)
  ) u_mul (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .i_en    (w_adv),
    .i_flush (w_clr),
    .i_valid (w_accept),
    .i_a     (din0),
    .i_b     (din1),
    .o_prod  (w_prod),
    .o_valid (w_prod_vld),
    .o_busy  (w_pipe_busy)
  );

  assign w_fire     = w_adv && !acc_clr && w_prod_vld;
  assign w_load     = w_fire && (r_tap == TAP_LAST);
  assign w_prod_ext = ACC_WIDTH'(w_prod);
  assign w_base     = (r_tap == '0) ? '0 : r_acc;
  assign w_sum      = w_base + w_prod_ext;
  assign w_shifted  = w_sum >>> OUT_SHIFT;

`ifdef CONV_MAC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

  logic r_sat;
  logic w_sat;

  always_comb begin
    w_fmt = DOUT_WIDTH'(w_shifted);
    w_sat = 1'b0;
    if (w_shifted > SAT_MAX) begin
      w_fmt = DOUT_WIDTH'(SAT_MAX);
      w_sat = 1'b1;
    end else if (w_shifted < SAT_MIN) begin
      w_fmt = DOUT_WIDTH'(SAT_MIN);
      w_sat = 1'b1;
    end
  end

  assign sat_flag = r_sat;
`else
  assign w_fmt = DOUT_WIDTH'(w_shifted);
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_tap       <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_dout      <= '0;
`ifdef CONV_MAC_SAT_EN
      r_sat       <= 1'b0;
`endif
    end else begin
      if (w_clr) begin
        r_tap <= '0;
        r_acc <= '0;
      end else if (w_fire) begin
        r_acc <= w_sum;
        r_tap <= (r_tap == TAP_LAST) ? '0 : r_tap + 1'b1;
      end
      // acc_clr never touches the output register; a pending result survives an abort.
      if (w_adv) begin
        r_out_valid <= w_load;
      end
      if (w_load) begin
        r_dout <= w_fmt;
`ifdef CONV_MAC_SAT_EN
        r_sat  <= w_sat;
`endif
      end
    end
  end

  assign out_valid = r_out_valid;
  assign dout      = r_dout;
  assign busy      = w_pipe_busy || (r_tap != '0);

endmodule
